// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display blocks: digit count,
// active-low hex font (bit 6 = a .. bit 0 = g) and the all-off pattern.
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] FONT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // True when every digit from position idx up to the top digit is zero.
  function automatic logic upper_all_zero(input logic [31:0] dig, input logic [2:0] idx);
    logic nz;
    nz = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(idx)) && (dig[4*i +: 4] != 4'h0)) begin
        nz = 1'b1;
      end else begin
        nz = nz;
      end
    end
    return !nz;
  endfunction

endpackage

// File: rtl/seg_scan_driver_hex_to_seg_n.sv
// Combinational 4-bit hex to active-low seven-segment decoder.
module hex_to_seg_n
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  // Look the nibble up in the shared font table.
  always_comb begin
    seg_n = FONT[hex];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit common-anode seven-segment driver with a
// frame-synchronous double buffer and dead time at each digit change.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIV_W     = 17,
  parameter int BLANK_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digits,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  digit_en,
  input  logic        lz_en,
  input  logic        load,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_tick
);

  localparam logic [DIV_W-1:0] BLANK_V = DIV_W'(BLANK_CYC);
  localparam logic [DIV_W-1:0] ONE_V   = DIV_W'(1);
  localparam logic [DIV_W-1:0] ZERO_V  = {DIV_W{1'b0}};

  logic [DIV_W-1:0] pre_r, pre_nxt_s;
  logic [2:0]       idx_r, idx_nxt_s;
  logic [DIV_W-1:0] blk_r, blk_nxt_s;
  logic [31:0]      shd_dig_r, shd_dig_nxt_s;
  logic [7:0]       shd_dp_r, shd_dp_nxt_s;
  logic [31:0]      act_dig_r, act_dig_nxt_s;
  logic [7:0]       act_dp_r, act_dp_nxt_s;
  logic             pending_r, pending_nxt_s;

  logic             tc_s;
  logic             wrap_s;
  logic [3:0]       nib_s;
  logic [6:0]       font_s;
  logic             suppress_s;
  logic [7:0]       an_nxt_s;
  logic [6:0]       seg_nxt_s;
  logic             dp_nxt_s;

  assign tc_s   = &pre_r;
  assign wrap_s = tc_s && (idx_r == 3'd7);

  // Scan, blank and double-buffer next-state logic.
  always_comb begin
    pre_nxt_s     = pre_r + ONE_V;
    idx_nxt_s     = idx_r;
    blk_nxt_s     = blk_r;
    shd_dig_nxt_s = shd_dig_r;
    shd_dp_nxt_s  = shd_dp_r;
    act_dig_nxt_s = act_dig_r;
    act_dp_nxt_s  = act_dp_r;
    pending_nxt_s = pending_r;

    if (tc_s) begin
      idx_nxt_s = idx_r + 3'd1;
      blk_nxt_s = BLANK_V;
    end else if (blk_r != ZERO_V) begin
      blk_nxt_s = blk_r - ONE_V;
    end else begin
      blk_nxt_s = blk_r;
    end

    if (load) begin
      shd_dig_nxt_s = digits;
      shd_dp_nxt_s  = dp_in;
      pending_nxt_s = 1'b1;
    end else begin
      pending_nxt_s = pending_r;
    end

    // A load in the wrap cycle goes straight to the active copy.
    if (wrap_s) begin
      if (load) begin
        act_dig_nxt_s = digits;
        act_dp_nxt_s  = dp_in;
      end else if (pending_r) begin
        act_dig_nxt_s = shd_dig_r;
        act_dp_nxt_s  = shd_dp_r;
      end else begin
        act_dig_nxt_s = act_dig_r;
        act_dp_nxt_s  = act_dp_r;
      end
      pending_nxt_s = 1'b0;
    end else begin
      act_dig_nxt_s = act_dig_r;
      act_dp_nxt_s  = act_dp_r;
    end
  end

  assign nib_s = act_dig_nxt_s[{idx_nxt_s, 2'b00} +: 4];

  hex_to_seg_n u_dec (
    .hex   (nib_s),
    .seg_n (font_s)
  );

  assign suppress_s = lz_en && (idx_nxt_s != 3'd0) && upper_all_zero(act_dig_nxt_s, idx_nxt_s);

  // Output pattern for the digit that will be current after this edge.
  always_comb begin
    an_nxt_s  = 8'hFF;
    seg_nxt_s = SEG_BLANK;
    dp_nxt_s  = 1'b1;

    if (blk_nxt_s != ZERO_V) begin
      an_nxt_s = 8'hFF;
    end else if (digit_en[idx_nxt_s]) begin
      an_nxt_s = ~(8'd1 << idx_nxt_s);
    end else begin
      an_nxt_s = 8'hFF;
    end

    if (suppress_s) begin
      seg_nxt_s = SEG_BLANK;
      dp_nxt_s  = 1'b1;
    end else begin
      seg_nxt_s = font_s;
      dp_nxt_s  = ~act_dp_nxt_s[idx_nxt_s];
    end
  end

  // Scan counters and digit buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_r     <= ZERO_V;
      idx_r     <= 3'd0;
      blk_r     <= BLANK_V;
      shd_dig_r <= 32'h0000_0000;
      shd_dp_r  <= 8'h00;
      act_dig_r <= 32'h0000_0000;
      act_dp_r  <= 8'h00;
      pending_r <= 1'b0;
    end else begin
      pre_r     <= pre_nxt_s;
      idx_r     <= idx_nxt_s;
      blk_r     <= blk_nxt_s;
      shd_dig_r <= shd_dig_nxt_s;
      shd_dp_r  <= shd_dp_nxt_s;
      act_dig_r <= act_dig_nxt_s;
      act_dp_r  <= act_dp_nxt_s;
      pending_r <= pending_nxt_s;
    end
  end

  // Registered display outputs; the frame tick marks the edge idx returns to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n       <= 8'hFF;
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an_n       <= an_nxt_s;
      seg_n      <= seg_nxt_s;
      dp_n       <= dp_nxt_s;
      frame_tick <= wrap_s;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (DIV_W=4, BLANK_CYC=2).
module tb_seg_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [31:0] digits;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic        lz_en;
  logic        load;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_tick;

  int tests;
  int fails;
  int pos;

  seg_scan_driver #(.DIV_W(4), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits     (digits),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .lz_en      (lz_en),
    .load       (load),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    pos++;
  endtask

  task automatic adv_to(input int t);
    while (pos < t) step();
  endtask

  task automatic pulse_load(input logic [31:0] d, input logic [7:0] dp);
    digits = d;
    dp_in  = dp;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  // Advance to the first negedge showing frame_tick; pos becomes 0 there.
  task automatic wait_tick();
    int n;
    n = 0;
    step();
    while (frame_tick !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    tests++;
    if (frame_tick !== 1'b1) begin
      fails++;
      $display("FAIL wait_tick: frame_tick=%b after %0d cycles, expected 1", frame_tick, n);
    end
    pos = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (an_n !== 8'hFF) begin fails++; $display("FAIL rst_an got %h exp ff", an_n); end
    tests++; if (seg_n !== 7'h7F) begin fails++; $display("FAIL rst_seg got %h exp 7f", seg_n); end
    tests++; if (dp_n !== 1'b1) begin fails++; $display("FAIL rst_dp got %b exp 1", dp_n); end
    tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL rst_tick got %b exp 0", frame_tick); end
    rst_n = 1'b1;
    step();
    tests++; if (an_n !== 8'hFF) begin fails++; $display("FAIL rst_dark1 got %h exp ff", an_n); end
    step();
    tests++; if (an_n !== 8'hFE) begin fails++; $display("FAIL rst_first_digit got %h exp fe", an_n); end
    tests++; if (seg_n !== 7'b0000001) begin fails++; $display("FAIL rst_first_seg got %b exp 0000001", seg_n); end
  endtask

  task automatic test_basic_scan();
    pulse_load(32'h76543210, 8'h00);
    wait_tick();
    tests++; if (seg_n !== 7'b0000001) begin fails++; $display("FAIL basic_seg0 got %b exp 0000001", seg_n); end
    tests++; if (an_n !== 8'hFF) begin fails++; $display("FAIL basic_blank0a got %h exp ff", an_n); end
    adv_to(1);
    tests++; if (an_n !== 8'hFF) begin fails++; $display("FAIL basic_blank0b got %h exp ff", an_n); end
    adv_to(2);
    tests++; if (an_n !== 8'hFE) begin fails++; $display("FAIL basic_an0 got %h exp fe", an_n); end
    tests++; if (dp_n !== 1'b1) begin fails++; $display("FAIL basic_dp0 got %b exp 1", dp_n); end
    adv_to(16);
    tests++; if (an_n !== 8'hFF) begin fails++; $display("FAIL basic_blank1a got %h exp ff", an_n); end
    tests++; if (seg_n !== 7'b1001111) begin fails++; $display("FAIL basic_seg1 got %b exp 1001111", seg_n); end
    adv_to(17);
    tests++; if (an_n !== 8'hFF) begin fails++; $display("FAIL basic_blank1b got %h exp ff", an_n); end
    adv_to(18);
    tests++; if (an_n !== 8'hFD) begin fails++; $display("FAIL basic_an1 got %h exp fd", an_n); end
  endtask

  task automatic test_mid_frame_load();
    adv_to(50);
    tests++; if (an_n !== 8'hF7) begin fails++; $display("FAIL mid_an3 got %h exp f7", an_n); end
    tests++; if (seg_n !== 7'b0000110) begin fails++; $display("FAIL mid_seg3 got %b exp 0000110", seg_n); end
    pulse_load(32'hFEDCBA98, 8'h00);
    adv_to(114);
    tests++; if (an_n !== 8'h7F) begin fails++; $display("FAIL mid_an7 got %h exp 7f", an_n); end
    tests++; if (seg_n !== 7'b0001111) begin fails++; $display("FAIL mid_old7 got %b exp 0001111", seg_n); end
    wait_tick();
    tests++; if (seg_n !== 7'b0000000) begin fails++; $display("FAIL mid_new0 got %b exp 0000000", seg_n); end
    adv_to(114);
    tests++; if (seg_n !== 7'b0111000) begin fails++; $display("FAIL mid_new7 got %b exp 0111000", seg_n); end
  endtask

  task automatic test_wrap_load();
    int extra;
    extra = 0;
    adv_to(127);
    pulse_load(32'h1234567C, 8'h00);
    pos = 0;
    tests++; if (frame_tick !== 1'b1) begin fails++; $display("FAIL wrap_tick got %b exp 1", frame_tick); end
    tests++; if (seg_n !== 7'b0110001) begin fails++; $display("FAIL wrap_seg0 got %b exp 0110001", seg_n); end
    for (int p = 1; p < 128; p++) begin
      step();
      if (frame_tick === 1'b1) extra++;
      if (p == 2) begin
        tests++; if (an_n !== 8'hFE) begin fails++; $display("FAIL wrap_an0 got %h exp fe", an_n); end
      end
    end
    tests++; if (extra !== 0) begin fails++; $display("FAIL wrap_tick_once extra pulses %0d exp 0", extra); end
  endtask

  task automatic test_lz();
    logic [6:0] exp_seg [8];
    exp_seg[0] = 7'b0100100; exp_seg[1] = 7'b0000001; exp_seg[2] = 7'b0000110;
    for (int k = 3; k < 8; k++) exp_seg[k] = 7'h7F;
    lz_en = 1'b1;
    pulse_load(32'h00000305, 8'h00);
    wait_tick();
    for (int k = 0; k < 8; k++) begin
      adv_to(16 * k + 2);
      tests++; if (seg_n !== exp_seg[k]) begin fails++; $display("FAIL lz_seg%0d got %b exp %b", k, seg_n, exp_seg[k]); end
      tests++; if (an_n !== ~(8'h01 << k)) begin fails++; $display("FAIL lz_an%0d got %h exp %h", k, an_n, ~(8'h01 << k)); end
      tests++; if (dp_n !== 1'b1) begin fails++; $display("FAIL lz_dp%0d got %b exp 1", k, dp_n); end
    end
    lz_en = 1'b0;
    step();
    tests++; if (seg_n !== 7'b0000001) begin fails++; $display("FAIL lz_live_off got %b exp 0000001", seg_n); end
  endtask

  task automatic test_digit_en_dp();
    logic exp_dp;
    digit_en = 8'h05;
    pulse_load(32'h76543210, 8'h04);
    wait_tick();
    for (int p = 0; p < 128; p++) begin
      if (p > 0) step();
      tests++;
      if (!(an_n === 8'hFE || an_n === 8'hFB || an_n === 8'hFF)) begin
        fails++; $display("FAIL en_an_set pos %0d got %h exp fe/fb/ff", p, an_n);
      end
      exp_dp = ((p / 16) == 2) ? 1'b0 : 1'b1;
      tests++; if (dp_n !== exp_dp) begin fails++; $display("FAIL en_dp pos %0d got %b exp %b", p, dp_n, exp_dp); end
      if (p == 18) begin
        tests++; if (an_n !== 8'hFF) begin fails++; $display("FAIL en_an1_off got %h exp ff", an_n); end
      end
      if (p == 34) begin
        tests++; if (an_n !== 8'hFB) begin fails++; $display("FAIL en_an2_on got %h exp fb", an_n); end
      end
    end
  endtask

  task automatic test_reset_mid_blank();
    digit_en = 8'hFF;
    step();
    pos = 0;
    adv_to(5);
    pulse_load(32'hFFFFFFFF, 8'hFF);
    adv_to(49);
    rst_n = 1'b0;
    #1;
    tests++; if (an_n !== 8'hFF) begin fails++; $display("FAIL mrst_an got %h exp ff", an_n); end
    tests++; if (seg_n !== 7'h7F) begin fails++; $display("FAIL mrst_seg got %h exp 7f", seg_n); end
    tests++; if (dp_n !== 1'b1) begin fails++; $display("FAIL mrst_dp got %b exp 1", dp_n); end
    step();
    step();
    rst_n = 1'b1;
    step();
    tests++; if (an_n !== 8'hFF) begin fails++; $display("FAIL mrst_dark got %h exp ff", an_n); end
    step();
    tests++; if (an_n !== 8'hFE) begin fails++; $display("FAIL mrst_first got %h exp fe", an_n); end
    wait_tick();
    tests++; if (seg_n !== 7'b0000001) begin fails++; $display("FAIL mrst_lost_seg got %b exp 0000001", seg_n); end
    tests++; if (dp_n !== 1'b1) begin fails++; $display("FAIL mrst_lost_dp got %b exp 1", dp_n); end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    pos      = 0;
    rst_n    = 1'b0;
    digits   = 32'h0000_0000;
    dp_in    = 8'h00;
    digit_en = 8'hFF;
    lz_en    = 1'b0;
    load     = 1'b0;
    test_reset();
    test_basic_scan();
    test_mid_frame_load();
    test_wrap_load();
    test_lz();
    test_digit_en_dp();
    test_reset_mid_blank();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for the 8-digit common-anode seven-segment display. It takes eight 4-bit hex digits from the counter stage and scans one digit at a time onto the shared, active-low segment and anode lines. Digits are double-buffered and swapped only at a frame boundary, so a display never shows a torn value. A dead-time interval is inserted at each digit change to suppress ghosting.

## Interface
Parameters:
- `DIV_W`, default 17: prescaler width; the scan advances one digit every 2^DIV_W clocks (about 763 Hz per digit at 100 MHz).
- `BLANK_CYC`, default 64: all-anodes-off cycles after each digit change; legal range 1 .. 2^DIV_W-2.

Ports:
- `clk`  in  1  system clock (100 MHz board clock).
- `rst_n`  in  1  asynchronous, active-low reset.
- `digits`  in  32  digit i = `digits[4i+3:4i]`.
- `dp_in`  in  8  decimal point request per digit, active-high.
- `digit_en`  in  8  per-digit enable mask, sampled live each cycle.
- `lz_en`  in  1  leading-zero suppression enable, sampled live each cycle.
- `load`  in  1  single-cycle strobe that captures `digits` and `dp_in` into the shadow register.
- `an_n`  out  8  anode enables, active-low, at most one bit low at a time.
- `seg_n`  out  7  segments, active-low; bit 6 = a, down to bit 0 = g.
- `dp_n`  out  1  decimal point, active-low.
- `frame_tick`  out  1  one-cycle pulse when the scan wraps from digit 7 to digit 0.

## Operation
- Registers: prescaler `pre` (DIV_W bits), digit index `idx` (3 bits), blank counter `blk`, shadow digits and dp, active digits and dp, `pending` flag.
- `load` writes the shadow registers and sets `pending`.
- At wrap (idx 7→0): if `pending` or `load`, the active registers take the new value and `pending` clears. A `load` in the wrap cycle bypasses the shadow and is applied at that wrap.
- `pre` free-runs and wraps. At terminal count (all ones), `idx` increments modulo 8 and `blk` loads BLANK_CYC.
- While `blk` is non-zero, `an_n` = 8'hFF and `blk` decrements each cycle.
- When `blk` is zero, `an_n` = ~(1<<idx) if `digit_en[idx]`, otherwise 8'hFF.
- Segment decode uses the standard active-low hex font (a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Leading-zero suppression: when `lz_en`=1, `idx`>0, and active digits idx..7 are all zero, `seg_n` = 7'h7F and `dp_n` = 1. Digit 0 is never suppressed.
- `dp_n` = ~active_dp[idx].

## Timing
- Reset values:
  - `an_n`=8'hFF, `seg_n`=7'h7F, `dp_n`=1, `frame_tick`=0.
  - `pre`=0, `idx`=0, `pending`=0, shadow and active registers = 0.
  - `blk`=BLANK_CYC, so the display stays dark for the first BLANK_CYC cycles after reset release.
- All outputs are registered.
- If `pre` hits terminal count in cycle T:
  - From edge T+1, `seg_n`, `dp_n` and `idx` reflect the new digit, and `an_n`=8'hFF.
  - `an_n` selects the new digit from edge T+1+BLANK_CYC.
  - Segments therefore always settle under blank.
- `frame_tick` is high for exactly the one cycle after the edge at which `idx` becomes 0.
- Load-to-display latency is at most one full frame (8·2^DIV_W cycles) plus BLANK_CYC.
- Multiple `load`s within a frame: the last one wins.
- Reset asserted mid-scan: all outputs go to their reset values immediately (asynchronous), and a pending load is discarded.
- A `digit_en` or `lz_en` change takes effect on the next registered output, with no wait for a frame boundary.

## Structure
- `seg_pkg` holds NUM_DIGITS=8, the 16-entry active-low font constant array, and the `SEG_BLANK`=7'h7F constant.
- Sub-module `hex_to_seg_n` is the combinational 4-bit to 7-bit active-low decoder, indexing the package font. It is reusable by other display blocks.
- The top level holds the prescaler, index, blank counter, double buffer, and output registers.

## Test plan
All scenarios use DIV_W=4 and BLANK_CYC=2.
- Reset, then load `digits`=32'h76543210, `dp_in`=0, `digit_en`=8'hFF:
  - After the next wrap, digit 0 shows `an_n`=8'hFE with `seg_n`=7'b0000001.
  - Digit 1 shows `an_n`=8'hFD with `seg_n`=7'b1001111.
  - Exactly 2 all-off cycles separate consecutive digits.
- Load 32'hFEDCBA98 while `idx`=3: the display keeps showing old values through digit 7. The new values appear from digit 0, which shows `seg_n`=7'b0000000, and digit 7 shows 7'b0111000.
- `load` asserted in the same cycle as the 7→0 wrap: the new digit 0 value is shown in that same frame. `frame_tick` pulses once.
- `lz_en`=1 with `digits`=32'h00000305: digits 3..7 show `seg_n`=7'h7F. Digit 2 shows 3, digit 1 shows 0 (not suppressed), and digit 0 shows 5.
- `digit_en`=8'h05: `an_n` only ever takes 8'hFE, 8'hFB, or 8'hFF. `dp_in`=8'h04 gives `dp_n`=0 only while digit 2 is selected.
- Assert `rst_n` low mid-blank: the same cycle gives `an_n`=8'hFF and `seg_n`=7'h7F. After release, the display is dark for 2 cycles and pending data is lost.
